// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 width/sign codes for loads and stores
//   - lsu_state_e controller states
//   - lane helpers: little-endian byte/half pick, access-size decode, misalignment test
package lsu_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW,
    ST_ACK,
    ST_ERR
  } lsu_state_e;

  // Byte lane k lives in bits [8k+7:8k].
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] lane_half(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  // Access size is funct3[1:0] for both loads and stores: 00 byte, 01 half,
  // 1x word (covers the unused codes that fall back to word access).
  function automatic logic size_is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic size_is_word(input logic [2:0] f3);
    return f3[1];
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (size_is_half(f3) && off[0]) || (size_is_word(f3) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   word    in  32  memory word just read
//   off     in  2   byte offset within the word (addr[1:0])
//   funct3  in  3   RISC-V width/sign code
//   wdata   in  32  store data (low byte/half used for SB/SH)
//   ld_data out 32  extracted, sign/zero-extended load value
//   st_data out 32  word with the store lanes merged in
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] st_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = lane_byte(word, off);
    h = lane_half(word, off[1]);

    case (funct3)
      F3_LB:   ld_data = {{24{b[7]}}, b};
      F3_LH:   ld_data = {{16{h[15]}}, h};
      F3_LBU:  ld_data = {24'd0, b};
      F3_LHU:  ld_data = {16'd0, h};
      default: ld_data = word;
    endcase

    st_data = word;
    case (funct3[1:0])
      2'b00: st_data[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: st_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: st_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for a word-addressed data memory with a
// 1-cycle registered read. Handles LB/LH/LW/LBU/LHU/SB/SH/SW; SB/SH are done as
// read-modify-write, SW writes directly on the accept edge.
// Optional feature macro: MISALIGN_CHECK_EN (misaligned half/word -> resp_err).
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake (accept on posedge when both high)
//   req_we, req_funct3        store flag, RISC-V width/sign code
//   req_addr, req_wdata       byte address, store data
//   resp_valid/rdata/err      one-cycle completion pulse, load data, misalign flag
//   mem_we, mem_r_addr, mem_r_data, mem_w_addr, mem_w_data  memory side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              accept, misalign;
  logic [DATA_W-1:0] ld_data, st_data;

  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

`ifdef MISALIGN_CHECK_EN
  assign misalign = misaligned(req_funct3, req_addr[1:0]);
  assign resp_err = (state_q == ST_ERR);
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  // In IDLE the request address goes straight out so the read launches on
  // the accept edge; afterwards the captured address holds the word.
  assign mem_r_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign mem_w_addr = mem_r_addr;

  lsu_align u_align (
    .word    (mem_r_data),
    .off     (addr_q[1:0]),
    .funct3  (funct3_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
    end
  end

  always_comb begin
    addr_d   = accept ? req_addr   : addr_q;
    wdata_d  = accept ? req_wdata  : wdata_q;
    funct3_d = accept ? req_funct3 : funct3_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misalign)                       state_d = ST_ERR;
          else if (!req_we)                   state_d = ST_LOAD;
          else if (size_is_word(req_funct3))  state_d = ST_ACK;
          else                                state_d = ST_RMW;
        end
      end
      ST_RMW:  state_d = ST_ACK;
      default: state_d = ST_IDLE;  // LOAD, ACK, ERR all last one cycle
    endcase
  end

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_w_data = req_wdata;
    case (state_q)
      ST_IDLE: mem_we = accept & req_we & size_is_word(req_funct3) & ~misalign;
      ST_LOAD: begin
        resp_valid = 1'b1;
        resp_rdata = ld_data;
      end
      ST_RMW: begin
        // mem_r_data now holds the word read on the accept edge.
        mem_we     = ~rst;
        mem_w_data = st_data;
      end
      ST_ACK:  resp_valid = 1'b1;
      ST_ERR:  resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural
// word memory (registered read) and a response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data)
  );

  // Word memory: registered read, write on posedge when mem_we.
  logic [31:0] mem [0:1023];
  logic        preload = 1'b1;
  int          wr_cnt = 0;
  int          rv_cnt = 0;

  always @(posedge clk) begin
    mem_r_data <= mem[mem_r_addr[11:2]];
    if (preload) begin
      mem[10'h040] <= 32'h8899AABB;
      mem[10'h041] <= 32'h12345678;
    end else if (mem_we) begin
      mem[mem_w_addr[11:2]] <= mem_w_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (resp_valid) rv_cnt <= rv_cnt + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   last_ready_low = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Drive one request, wait (bounded) for its response, then pop the
  // scoreboard entry and compare data, error flag and latency.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0;
    lat = 0;
    last_ready_low = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!req_ready) last_ready_low++;
      if (resp_valid) begin lat = i; break; end
    end
    e = sb_q.pop_front();
    if (lat == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
      chk({tag, "_lat"}, lat, e.lat);
    end
  endtask

  int w0, r0;

  initial begin
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_err", {31'd0, resp_err}, 32'd0);

    // Loads from 0x100 = 0x8899AABB
    do_req("LB_101",  1'b0, F3_LB,  32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 1);
    do_req("LBU_101", 1'b0, F3_LBU, 32'h101, 32'h0, 32'h000000AA, 1'b0, 1);
    do_req("LH_102",  1'b0, F3_LH,  32'h102, 32'h0, 32'hFFFF8899, 1'b0, 1);
    do_req("LHU_100", 1'b0, F3_LHU, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 1);
    do_req("LW_100",  1'b0, F3_LW,  32'h100, 32'h0, 32'h8899AABB, 1'b0, 1);
    do_req("LBU_103", 1'b0, F3_LBU, 32'h103, 32'h0, 32'h00000088, 1'b0, 1);
    do_req("L111_100", 1'b0, 3'b111, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 1);
    do_req("LW_104",  1'b0, F3_LW,  32'h104, 32'h0, 32'h12345678, 1'b0, 1);

`ifdef MISALIGN_CHECK_EN
    do_req("LW_102_mis", 1'b0, F3_LW, 32'h102, 32'h0, 32'h0, 1'b1, 1);
`else
    do_req("LW_102_down", 1'b0, F3_LW, 32'h102, 32'h0, 32'h8899AABB, 1'b0, 1);
`endif

    // SB: read-modify-write, one write, ready low for RMW+ACK (3 cycles of
    // occupancy counting the accept cycle).
    w0 = wr_cnt;
    do_req("SB_103", 1'b1, F3_SB, 32'h103, 32'h00000011, 32'h0, 1'b0, 2);
    chk("SB_writes", wr_cnt - w0, 32'd1);
    chk("SB_ready_low", last_ready_low, 32'd2);
    chk("SB_mem", mem[10'h040], 32'h1199AABB);
    do_req("LW_after_SB", 1'b0, F3_LW, 32'h100, 32'h0, 32'h1199AABB, 1'b0, 1);

    // SH upper half
    do_req("SH_102", 1'b1, F3_SH, 32'h102, 32'hCAFE7777, 32'h0, 1'b0, 2);
    do_req("LW_after_SH", 1'b0, F3_LW, 32'h100, 32'h0, 32'h7777AABB, 1'b0, 1);

    // SW then LW right after ACK
    w0 = wr_cnt;
    do_req("SW_200", 1'b1, F3_SW, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    chk("SW_writes", wr_cnt - w0, 32'd1);
    do_req("LW_200", 1'b0, F3_LW, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 1);

    // store funct3 111 behaves as SW
    do_req("S111_204", 1'b1, 3'b111, 32'h204, 32'h0BADF00D, 32'h0, 1'b0, 1);
    do_req("LW_204", 1'b0, F3_LW, 32'h204, 32'h0, 32'h0BADF00D, 1'b0, 1);

    // Reset during RMW of SH 0x104: no write, no response
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_SH; req_addr = 32'h104; req_wdata = 32'h0000BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0;
    w0 = wr_cnt; r0 = rv_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmw_rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rmw_rst_writes", wr_cnt - w0, 32'd0);
    chk("rmw_rst_resp", rv_cnt - r0, 32'd0);
    chk("rmw_rst_mem", mem[10'h041], 32'h12345678);
    do_req("LW_104_after_rst", 1'b0, F3_LW, 32'h104, 32'h0, 32'h12345678, 1'b0, 1);

`ifdef MISALIGN_CHECK_EN
    w0 = wr_cnt;
    do_req("SH_105_mis", 1'b1, F3_SH, 32'h105, 32'h00005555, 32'h0, 1'b1, 1);
    chk("SH_105_writes", wr_cnt - w0, 32'd0);
    chk("SH_105_mem", mem[10'h041], 32'h12345678);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
